// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed little-endian data memory behind a valid/ready request
// channel, with a one-cycle response strobe, access sizing and fault detection.
//
// state  | meaning
// IDLE   | ready for a request; ready_o high
// WAIT   | request captured, counting wait cycles
// RESP   | rvalid_o high for one cycle with rdata_o/err_o
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]            MemType_i,
    input  logic                  MemSign_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            type_q;
    logic                  sign_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q;

    logic [7:0] mem_q [0:DEPTH-1];

    logic                  accept;
    logic                  enter_resp;
    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [1:0]            cur_type;
    logic                  cur_sign;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]            b0, b1, b2, b3;
    logic [31:0]           ld_data;

    assign ready_o  = (state_q == S_IDLE);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign accept = req_i && (state_q == S_IDLE);

    // With zero latency the response is formed on the accept edge straight from the inputs.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_type  = type_q;
        cur_sign  = sign_q;
        if (state_q == S_IDLE) begin
            cur_we    = we_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
            cur_type  = MemType_i;
            cur_sign  = MemSign_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = 4'd0;
                    if (LATENCY == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == LAT_C) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fault = (cur_type == 2'b11)
             || ((cur_type == 2'b01) && cur_addr[0])
             || ((cur_type == 2'b10) && (cur_addr[1:0] != 2'b00))
             || (|cur_addr[31:ADDR_WIDTH]);
        // Upper-byte indices are only meaningful for aligned accesses, which faults guarantee.
        idx0 = cur_addr[ADDR_WIDTH-1:0];
        idx1 = {idx0[ADDR_WIDTH-1:1], 1'b1};
        idx2 = {idx0[ADDR_WIDTH-1:2], 2'b10};
        idx3 = {idx0[ADDR_WIDTH-1:2], 2'b11};
        b0 = mem_q[idx0];
        b1 = mem_q[idx1];
        b2 = mem_q[idx2];
        b3 = mem_q[idx3];
        case (cur_type)
            2'b00:   ld_data = {{24{cur_sign & b0[7]}}, b0};
            2'b01:   ld_data = {{16{cur_sign & b1[7]}}, b1, b0};
            2'b10:   ld_data = {b3, b2, b1, b0};
            default: ld_data = 32'd0;
        endcase
        rdata_d = (fault || cur_we) ? '0 : ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= '0;
            type_q   <= 2'b00;
            sign_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= enter_resp;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                type_q  <= MemType_i;
                sign_q  <= MemSign_i;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= fault;
            end
        end
    end

    // Array is deliberately not reset; rst gating keeps a held reset from committing a store.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && cur_we && !fault) begin
            mem_q[idx0] <= cur_wdata[7:0];
            if (cur_type != 2'b00) begin
                mem_q[idx1] <= cur_wdata[15:8];
            end
            if (cur_type == 2'b10) begin
                mem_q[idx2] <= cur_wdata[23:16];
                mem_q[idx3] <= cur_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-array reference model;
// one instance at LATENCY=2 and one at LATENCY=0 for back-to-back traffic.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;

    logic        req2, we2, sign2;
    logic [31:0] addr2, wdata2;
    logic [1:0]  type2;
    logic        ready2, rvalid2, err2;
    logic [31:0] rdata2;

    logic        req0, we0, sign0;
    logic [31:0] addr0, wdata0;
    logic [1:0]  type0;
    logic        ready0, rvalid0, err0;
    logic [31:0] rdata0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses0  = 0;
    int viol0    = 0;

    logic [7:0]  mm [0:4095];

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
        .MemType_i(type2), .MemSign_i(sign2), .ready_o(ready2), .rvalid_o(rvalid2),
        .rdata_o(rdata2), .err_o(err2)
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wdata0),
        .MemType_i(type0), .MemSign_i(sign0), .ready_o(ready0), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid0) pulses0 <= pulses0 + 1;
        if (rvalid0 && ready0) viol0 <= viol0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_fault(input logic [31:0] a, input logic [1:0] mt);
        return (mt == 2'b11) || (mt == 2'b01 && a % 2 != 0) || (mt == 2'b10 && a % 4 != 0)
            || (a >= 32'd4096);
    endfunction

    function automatic int m_size(input logic [1:0] mt);
        return (mt == 2'b00) ? 1 : (mt == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] mt, input logic sg);
        logic [31:0] v;
        int n;
        n = m_size(mt);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v + (32'(mm[int'(a) + i]) << (8 * i));
        if (sg && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] mt, input logic [31:0] wd);
        for (int i = 0; i < m_size(mt); i++) mm[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] mt, input logic sg, input string tag,
                          output logic [31:0] got);
        int k;
        logic        exp_e;
        logic [31:0] exp_d;
        exp_e = m_fault(a, mt);
        exp_d = (exp_e || we) ? 32'd0 : m_load(a, mt, sg);
        chk({tag, "_ready_idle"}, 32'(ready2), 32'd1);
        req2 = 1'b1; we2 = we; addr2 = a; wdata2 = wd; type2 = mt; sign2 = sg;
        @(posedge clk); #1;
        req2 = 1'b0; we2 = 1'($urandom); addr2 = $urandom; wdata2 = $urandom;
        type2 = 2'($urandom); sign2 = 1'($urandom);
        chk({tag, "_ready_busy"}, 32'(ready2), 32'd0);
        k = 0;
        while (!rvalid2 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'd3);
        chk({tag, "_rdata"}, rdata2, exp_d);
        chk({tag, "_err"}, 32'(err2), 32'(exp_e));
        got = rdata2;
        if (we && !exp_e) m_store(a, mt, wd);
        @(posedge clk); #1;
        chk({tag, "_rvalid_drop"}, 32'(rvalid2), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready2), 32'd1);
        chk({tag, "_rdata_hold"}, rdata2, exp_d);
        chk({tag, "_err_hold"}, 32'(err2), 32'(exp_e));
    endtask

    logic [31:0] got;
    logic [31:0] vals [0:3];
    int t_prev, g, p0, r;
    logic [31:0] ra;
    logic [1:0]  rmt;

    initial begin
        rst = 1'b0;
        req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0; type2 = 0; sign2 = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; type0 = 0; sign0 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready2), 32'd1);
        chk("rst_rvalid", 32'(rvalid2), 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) do_req(1'b1, 32'h200 + 32'(4 * i), $urandom, 2'b10, 1'b0, "init", got);
        do_req(1'b1, 32'h010, 32'h11223344, 2'b10, 1'b0, "st010", got);
        do_req(1'b0, 32'h010, 32'd0, 2'b10, 1'b0, "ld010", got);
        chk("ld010_lit", got, 32'h11223344);

        // Reset mid-WAIT discards the pending store.
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h010; wdata2 = 32'hCAFEF00D; type2 = 2'b10;
        @(posedge clk); #1;
        req2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_ready", 32'(ready2), 32'd1);
        chk("arst_rvalid", 32'(rvalid2), 32'd0);
        chk("arst_rdata", rdata2, 32'd0);
        chk("arst_err", 32'(err2), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("arst_rvalid_held", 32'(rvalid2), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h010, 32'd0, 2'b10, 1'b0, "ld010_post", got);
        chk("ld010_post_lit", got, 32'h11223344);

        do_req(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, "st_w", got);
        do_req(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, "ld_w", got);
        chk("ld_w_lit", got, 32'hDEADBEEF);
        do_req(1'b0, 32'h103, 32'd0, 2'b00, 1'b1, "ld_bs", got);
        chk("ld_bs_lit", got, 32'hFFFFFFDE);
        do_req(1'b0, 32'h103, 32'd0, 2'b00, 1'b0, "ld_bu", got);
        chk("ld_bu_lit", got, 32'h000000DE);
        do_req(1'b0, 32'h100, 32'd0, 2'b01, 1'b1, "ld_hs", got);
        chk("ld_hs_lit", got, 32'hFFFFBEEF);
        do_req(1'b0, 32'h100, 32'd0, 2'b01, 1'b0, "ld_hu", got);
        chk("ld_hu_lit", got, 32'h0000BEEF);
        do_req(1'b1, 32'h101, 32'hFFFFFF5A, 2'b00, 1'b0, "st_b", got);
        do_req(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, "ld_w2", got);
        chk("ld_w2_lit", got, 32'hDEAD5AEF);

        do_req(1'b0, 32'h102, 32'd0, 2'b10, 1'b0, "f_ldw", got);
        do_req(1'b0, 32'h101, 32'd0, 2'b01, 1'b1, "f_ldh", got);
        do_req(1'b0, 32'h100, 32'd0, 2'b11, 1'b0, "f_ty", got);
        do_req(1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, "f_stoor", got);
        do_req(1'b1, 32'h101, 32'h00001234, 2'b01, 1'b0, "f_sth", got);
        do_req(1'b1, 32'h100, 32'h87654321, 2'b11, 1'b0, "f_stty", got);
        do_req(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, "ld_w3", got);
        chk("ld_w3_lit", got, 32'hDEAD5AEF);
        do_req(1'b0, 32'h000, 32'd0, 2'b10, 1'b0, "oor_low_ok", got);

        for (int n = 0; n < 120; n++) begin
            r   = int'($urandom_range(0, 15));
            rmt = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ra  = 32'h200 + 32'($urandom_range(0, 63));
            if (r == 1) ra = 32'h1000 + 32'($urandom_range(0, 4095));
            if (r == 2) ra = $urandom | 32'h0001_0000;
            do_req(1'($urandom_range(0, 1)), ra, $urandom, rmt, 1'($urandom_range(0, 1)), "rnd", got);
        end

        // Zero-latency instance with req held high.
        vals[0] = 32'hA5A5_0001; vals[1] = 32'h0BAD_F00D;
        vals[2] = 32'h8000_7FFF; vals[3] = 32'h1357_9BDF;
        for (int pass = 0; pass < 2; pass++) begin
            p0 = pulses0;
            req0 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                we0 = (pass == 0); addr0 = 32'h40 + 32'(4 * i); wdata0 = vals[i];
                type0 = 2'b10; sign0 = 1'b0;
                g = 0;
                while (!ready0 && g < 10) begin
                    @(posedge clk); #1;
                    g++;
                end
                @(posedge clk); #1;
                if (i > 0) chk("b2b_spacing", 32'(cyc - t_prev), 32'd2);
                t_prev = cyc;
                chk("b2b_rvalid", 32'(rvalid0), 32'd1);
                chk("b2b_err", 32'(err0), 32'd0);
                chk("b2b_rdata", rdata0, (pass == 0) ? 32'd0 : vals[i]);
            end
            req0 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("b2b_pulses", 32'(pulses0 - p0), 32'd4);
        end
        chk("b2b_ready_in_resp", 32'(viol0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
